// File: rtl/key_access_gate.sv
// key_access_gate: request gate in front of a key store, with bad-code lockout,
// idle relock and a one-way seal. Define KEY_READBACK_EN to permit READ.
module key_access_gate #(
  parameter int unsigned      KEY_W          = 32,
  parameter logic [KEY_W-1:0] UNLOCK_CODE    = 32'hA5C3_0F1E,
  parameter int unsigned      MAX_FAILS      = 3,
  parameter int unsigned      LOCKOUT_CYCLES = 1024,
  parameter int unsigned      IDLE_TIMEOUT   = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [KEY_W-1:0] req_data,
  output logic             resp_valid,
  output logic             resp_ok,
  output logic [KEY_W-1:0] key_wr_data,
  output logic             key_wr_en,
  output logic             key_rd_en,
  output logic             locked_out,
  output logic             sealed
);

  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [1:0] OP_UNLOCK = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_SEAL   = 2'b11;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2,
    ST_SEALED   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [FAIL_W-1:0] fail_cnt_r;
  logic [IDLE_W-1:0] idle_cnt_r;
  logic [LOCK_W-1:0] lock_cnt_r;
  logic              accept_s;
  logic              code_ok_s;
  logic              fail_hit_s;
  logic              idle_expire_s;
  logic              lock_expire_s;
  logic              grant_s;
  logic              wr_s;
`ifdef KEY_READBACK_EN
  logic              rd_s;
`endif

  assign accept_s      = req_valid && req_ready;
  assign code_ok_s     = (req_data == UNLOCK_CODE);
  // this bad code is the one that reaches MAX_FAILS
  assign fail_hit_s    = (fail_cnt_r >= FAIL_W'(MAX_FAILS - 1));
  assign idle_expire_s = (idle_cnt_r == IDLE_W'(IDLE_TIMEOUT - 1));
  assign lock_expire_s = (lock_cnt_r == LOCK_W'(LOCKOUT_CYCLES - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_LOCKED;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state decode; an accepted request in UNLOCKED beats the idle relock
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_LOCKED: begin
        if (accept_s && (req_op == OP_UNLOCK)) begin
          if (code_ok_s) begin
            state_s = ST_UNLOCKED;
          end else if (fail_hit_s) begin
            state_s = ST_LOCKOUT;
          end else begin
            state_s = ST_LOCKED;
          end
        end else begin
          state_s = ST_LOCKED;
        end
      end
      ST_UNLOCKED: begin
        if (accept_s) begin
          if (req_op == OP_SEAL) begin
            state_s = ST_SEALED;
          end else begin
            state_s = ST_UNLOCKED;
          end
        end else if (idle_expire_s) begin
          state_s = ST_LOCKED;
        end else begin
          state_s = ST_UNLOCKED;
        end
      end
      ST_LOCKOUT: begin
        if (lock_expire_s) begin
          state_s = ST_LOCKED;
        end else begin
          state_s = ST_LOCKOUT;
        end
      end
      ST_SEALED: state_s = ST_SEALED;
      default:   state_s = ST_LOCKED;
    endcase
  end

  // FSM output decode: grant and strobe values for the response cycle
  always_comb begin
    grant_s = 1'b0;
    wr_s    = 1'b0;
`ifdef KEY_READBACK_EN
    rd_s    = 1'b0;
`endif
    if (accept_s) begin
      case (state_r)
        ST_LOCKED:   grant_s = (req_op == OP_UNLOCK) && code_ok_s;
        ST_UNLOCKED: begin
          case (req_op)
            OP_UNLOCK: grant_s = 1'b1;
            OP_WRITE: begin
              grant_s = 1'b1;
              wr_s    = 1'b1;
            end
            OP_READ: begin
`ifdef KEY_READBACK_EN
              grant_s = 1'b1;
              rd_s    = 1'b1;
`else
              grant_s = 1'b0;
`endif
            end
            OP_SEAL:   grant_s = 1'b1;
            default:   grant_s = 1'b0;
          endcase
        end
        default:     grant_s = 1'b0;
      endcase
    end else begin
      grant_s = 1'b0;
    end
  end

  // fail, idle and lockout counters; all saturate instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_cnt_r <= {FAIL_W{1'b0}};
      idle_cnt_r <= {IDLE_W{1'b0}};
      lock_cnt_r <= {LOCK_W{1'b0}};
    end else begin
      case (state_r)
        ST_LOCKED: begin
          if (accept_s && (req_op == OP_UNLOCK)) begin
            if (code_ok_s) begin
              fail_cnt_r <= {FAIL_W{1'b0}};
            end else if (fail_cnt_r < FAIL_W'(MAX_FAILS)) begin
              fail_cnt_r <= fail_cnt_r + FAIL_W'(1);
            end else begin
              fail_cnt_r <= fail_cnt_r;
            end
          end else begin
            fail_cnt_r <= fail_cnt_r;
          end
        end
        ST_LOCKOUT: begin
          if (lock_expire_s) begin
            fail_cnt_r <= {FAIL_W{1'b0}};
          end else begin
            fail_cnt_r <= fail_cnt_r;
          end
        end
        default: fail_cnt_r <= fail_cnt_r;
      endcase

      if ((state_s != ST_UNLOCKED) || accept_s) begin
        idle_cnt_r <= {IDLE_W{1'b0}};
      end else if (idle_cnt_r < IDLE_W'(IDLE_TIMEOUT)) begin
        idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
      end else begin
        idle_cnt_r <= idle_cnt_r;
      end

      if ((state_r == ST_LOCKOUT) && (state_s == ST_LOCKOUT)
          && (lock_cnt_r < LOCK_W'(LOCKOUT_CYCLES))) begin
        lock_cnt_r <= lock_cnt_r + LOCK_W'(1);
      end else if (state_s == ST_LOCKOUT) begin
        lock_cnt_r <= lock_cnt_r;
      end else begin
        lock_cnt_r <= {LOCK_W{1'b0}};
      end
    end
  end

  // registered outputs; the key copy is wiped on entry to any non-unlocked state
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_ok     <= 1'b0;
      key_wr_en   <= 1'b0;
      key_wr_data <= {KEY_W{1'b0}};
      locked_out  <= 1'b0;
      sealed      <= 1'b0;
`ifdef KEY_READBACK_EN
      key_rd_en   <= 1'b0;
`endif
    end else begin
      req_ready  <= (state_s != ST_LOCKOUT);
      resp_valid <= accept_s;
      resp_ok    <= grant_s;
      key_wr_en  <= wr_s;
      locked_out <= (state_s == ST_LOCKOUT);
      sealed     <= (state_s == ST_SEALED);
`ifdef KEY_READBACK_EN
      key_rd_en  <= rd_s;
`endif
      if ((state_s != state_r) && (state_s != ST_UNLOCKED)) begin
        key_wr_data <= {KEY_W{1'b0}};
      end else if (wr_s) begin
        key_wr_data <= req_data;
      end else begin
        key_wr_data <= key_wr_data;
      end
    end
  end

`ifndef KEY_READBACK_EN
  assign key_rd_en = 1'b0;
`endif

endmodule

// File: tb/tb_key_access_gate.sv
// Self-checking bench for key_access_gate: vector table plus lockout, idle
// relock and in-flight reset sequences, with a response scoreboard.
module tb_key_access_gate;

  localparam logic [31:0] CODE = 32'hA5C3_0F1E;
  localparam logic [1:0]  U    = 2'b00;
  localparam logic [1:0]  W    = 2'b01;
  localparam logic [1:0]  R    = 2'b10;
  localparam logic [1:0]  S    = 2'b11;
`ifdef KEY_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct {
    bit          ok;
    bit          wr;
    bit          rd;
    logic [31:0] wdata;
    bit          sealed;
    bit          lockout;
  } exp_t;

  typedef struct {
    bit          rst_before;
    logic [1:0]  op;
    logic [31:0] data;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_data = 32'h0;
  logic        resp_valid;
  logic        resp_ok;
  logic [31:0] key_wr_data;
  logic        key_wr_en;
  logic        key_rd_en;
  logic        locked_out;
  logic        sealed;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[$];

  key_access_gate dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .resp_valid(resp_valid),
    .resp_ok(resp_ok), .key_wr_data(key_wr_data), .key_wr_en(key_wr_en),
    .key_rd_en(key_rd_en), .locked_out(locked_out), .sealed(sealed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit r, logic [1:0] op, logic [31:0] d, bit ok, bit wr,
                              bit rd, logic [31:0] wd, bit s, bit lo);
    vec_t v;
    v.rst_before = r; v.op = op; v.data = d;
    v.e.ok = ok; v.e.wr = wr; v.e.rd = rd; v.e.wdata = wd;
    v.e.sealed = s; v.e.lockout = lo;
    return v;
  endfunction

  // scoreboard consumer and strobe sanity, sampled on the falling edge
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_ok",     32'(resp_ok),    32'(mon_e.ok));
        chk("key_wr_en",   32'(key_wr_en),  32'(mon_e.wr));
        chk("key_rd_en",   32'(key_rd_en),  32'(mon_e.rd));
        chk("key_wr_data", key_wr_data,     mon_e.wdata);
        chk("sealed",      32'(sealed),     32'(mon_e.sealed));
        chk("locked_out",  32'(locked_out), 32'(mon_e.lockout));
      end
    end
    chk("wr_rd_exclusive", 32'(key_wr_en && key_rd_en), 32'd0);
    chk("strobe_ungranted", 32'((key_wr_en || key_rd_en) && !(resp_valid && resp_ok)), 32'd0);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_req(input vec_t v);
    @(negedge clk);
    chk("req_ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = v.op;
    req_data  = v.data;
    sb.push_back(v.e);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_data  = 32'h0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready",   32'(req_ready),  32'd1);
    chk("rst_resp_valid",  32'(resp_valid), 32'd0);
    chk("rst_resp_ok",     32'(resp_ok),    32'd0);
    chk("rst_key_wr_en",   32'(key_wr_en),  32'd0);
    chk("rst_key_rd_en",   32'(key_rd_en),  32'd0);
    chk("rst_key_wr_data", key_wr_data,     32'd0);
    chk("rst_locked_out",  32'(locked_out), 32'd0);
    chk("rst_sealed",      32'(sealed),     32'd0);
  endtask

  initial begin
    int cnt;
    //              rst op  data          ok  wr  rd  wdata         sl  lo
    tbl.push_back(mk(1, U, CODE,          1,  0,  0,  32'h0,        0,  0));
    tbl.push_back(mk(0, W, 32'hDEAD_BEEF, 1,  1,  0,  32'hDEAD_BEEF, 0, 0));
    tbl.push_back(mk(0, R, 32'h0,         RB, 0,  RB, 32'hDEAD_BEEF, 0, 0));
    tbl.push_back(mk(0, U, 32'h0,         1,  0,  0,  32'hDEAD_BEEF, 0, 0));
    tbl.push_back(mk(0, W, 32'h0BAD_F00D, 1,  1,  0,  32'h0BAD_F00D, 0, 0));
    tbl.push_back(mk(0, S, 32'h0,         1,  0,  0,  32'h0,        1,  0));
    tbl.push_back(mk(0, U, CODE,          0,  0,  0,  32'h0,        1,  0));
    tbl.push_back(mk(0, W, 32'h1234_5678, 0,  0,  0,  32'h0,        1,  0));
    tbl.push_back(mk(0, R, 32'h0,         0,  0,  0,  32'h0,        1,  0));
    tbl.push_back(mk(0, S, 32'h0,         0,  0,  0,  32'h0,        1,  0));
    tbl.push_back(mk(1, W, 32'h1234_5678, 0,  0,  0,  32'h0,        0,  0));
    tbl.push_back(mk(0, U, 32'h0,         0,  0,  0,  32'h0,        0,  0));
    tbl.push_back(mk(0, U, 32'h0,         0,  0,  0,  32'h0,        0,  0));
    tbl.push_back(mk(0, U, CODE,          1,  0,  0,  32'h0,        0,  0));
    tbl.push_back(mk(0, R, 32'h0,         RB, 0,  RB, 32'h0,        0,  0));
    tbl.push_back(mk(0, W, 32'h5A5A_5A5A, 1,  1,  0,  32'h5A5A_5A5A, 0, 0));
    tbl.push_back(mk(1, R, 32'h0,         0,  0,  0,  32'h0,        0,  0));
    tbl.push_back(mk(0, S, 32'h0,         0,  0,  0,  32'h0,        0,  0));
    tbl.push_back(mk(0, U, 32'hA5C3_0F1F, 0,  0,  0,  32'h0,        0,  0));
    tbl.push_back(mk(0, U, CODE,          1,  0,  0,  32'h0,        0,  0));

    do_reset();
    chk_reset_outputs();

    foreach (tbl[i]) begin
      if (tbl[i].rst_before) do_reset();
      do_req(tbl[i]);
    end

    // third consecutive bad code locks out for exactly LOCKOUT_CYCLES
    do_reset();
    do_req(mk(0, U, 32'h0, 0, 0, 0, 32'h0, 0, 0));
    do_req(mk(0, U, 32'h0, 0, 0, 0, 32'h0, 0, 0));
    do_req(mk(0, U, 32'h0, 0, 0, 0, 32'h0, 0, 1));
    chk("lockout_ready_low", 32'(req_ready), 32'd0);
    cnt = 0;
    while (!req_ready && cnt < 2000) begin
      req_valid = (cnt < 600);
      req_op    = U;
      req_data  = CODE;
      cnt++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("lockout_cycles", 32'(cnt), 32'd1024);
    chk("lockout_released", 32'(locked_out), 32'd0);
    do_req(mk(0, U, 32'h0, 0, 0, 0, 32'h0, 0, 0));
    do_req(mk(0, U, 32'h0, 0, 0, 0, 32'h0, 0, 0));
    do_req(mk(0, U, CODE,  1, 0, 0, 32'h0, 0, 0));

    // idle relock boundary: 255 idle cycles still granted, 256 relocks
    do_reset();
    do_req(mk(0, U, CODE, 1, 0, 0, 32'h0, 0, 0));
    repeat (254) @(negedge clk);
    do_req(mk(0, W, 32'h0000_0001, 1, 1, 0, 32'h0000_0001, 0, 0));
    repeat (255) @(negedge clk);
    do_req(mk(0, W, 32'h0000_0002, 0, 0, 0, 32'h0, 0, 0));
    do_req(mk(0, U, CODE, 1, 0, 0, 32'h0, 0, 0));
    do_req(mk(0, R, 32'h0, RB, 0, RB, 32'h0, 0, 0));

    // reset wins over a WRITE arriving on the same edge
    do_reset();
    do_req(mk(0, U, CODE, 1, 0, 0, 32'h0, 0, 0));
    do_req(mk(0, W, 32'hDEAD_BEEF, 1, 1, 0, 32'hDEAD_BEEF, 0, 0));
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = W;
    req_data  = 32'h1234_5678;
    rst       = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b0;
    chk_reset_outputs();
    do_req(mk(0, W, 32'h1234_5678, 0, 0, 0, 32'h0, 0, 0));

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_access_gate.md
KEY_ACCESS_GATE -- requirements
Module: key_access_gate

Interface
REQ-001 Parameter KEY_W, default 32, width of key and request data.
REQ-002 Parameter UNLOCK_CODE, default 32'hA5C3_0F1E, value an UNLOCK request must present.
REQ-003 Parameter MAX_FAILS, default 3, consecutive bad UNLOCKs before lockout.
REQ-004 Parameter LOCKOUT_CYCLES, default 1024, lockout duration in clk cycles.
REQ-005 Parameter IDLE_TIMEOUT, default 256, cycles without accepted request before an UNLOCKED session relocks.
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  gate can accept a request.
REQ-010 req_op  input  2  00 UNLOCK, 01 WRITE, 10 READ, 11 SEAL.
REQ-011 req_data  input  KEY_W  unlock code (UNLOCK) or key (WRITE); ignored otherwise.
REQ-012 resp_valid  output  1  one-cycle pulse, result of an accepted request.
REQ-013 resp_ok  output  1  qualified by resp_valid; 1 = granted, 0 = rejected.
REQ-014 key_wr_data  output  KEY_W  key toward downstream key storage write port.
REQ-015 key_wr_en  output  1  one-cycle write strobe to key storage.
REQ-016 key_rd_en  output  1  one-cycle read strobe to key storage.
REQ-017 locked_out  output  1  high while in LOCKOUT.
REQ-018 sealed  output  1  high while in SEALED.

Function
REQ-019 A request SHALL be accepted in the cycle req_valid && req_ready; resp_valid, resp_ok, key_wr_en/key_rd_en SHALL assert exactly one cycle later, for one cycle.
REQ-020 FSM states SHALL be LOCKED, UNLOCKED, LOCKOUT, SEALED; req_ready SHALL be 0 only in LOCKOUT.
REQ-021 LOCKED: UNLOCK with req_data==UNLOCK_CODE -> UNLOCKED, ok, fail count cleared; mismatch -> rejected, fail count +1.
REQ-022 LOCKED: fail count reaching MAX_FAILS SHALL move to LOCKOUT on that same request; WRITE/READ/SEAL rejected, fail count unchanged.
REQ-023 UNLOCKED: WRITE -> ok, key_wr_en pulse with key_wr_data=req_data; READ -> see Configuration; UNLOCK (any data) -> ok, stay, no fail count; SEAL -> ok, go SEALED.
REQ-024 UNLOCKED: idle counter SHALL reset on every accepted request and relock to LOCKED when it reaches IDLE_TIMEOUT without a request.
REQ-025 LOCKOUT: counter SHALL run LOCKOUT_CYCLES cycles, then enter LOCKED with fail count 0; no requests accepted meanwhile.
REQ-026 SEALED: every request accepted and rejected, no strobes, no fail counting; exit only by rst.
REQ-027 key_wr_data SHALL hold last written value and be zeroed whenever entering LOCKED, LOCKOUT or SEALED.
REQ-028 key_wr_en and key_rd_en SHALL never assert in the same cycle, nor outside a granted response.
REQ-029 Fail counter SHALL saturate at MAX_FAILS; idle/lockout counters SHALL not wrap.

Reset
REQ-030 rst SHALL force state LOCKED, fail/idle/lockout counters 0, all outputs 0 except req_ready=1, taking priority over any in-flight request (its response is dropped).

Configuration
REQ-031 Macro KEY_READBACK_EN defined: READ in UNLOCKED -> ok, key_rd_en pulse.
REQ-032 Macro KEY_READBACK_EN undefined: READ always rejected, key_rd_en tied 0.

Verification
REQ-033 After rst, UNLOCK 32'hA5C3_0F1E then WRITE 32'hDEAD_BEEF -> two ok responses, key_wr_en one pulse with key_wr_data=32'hDEAD_BEEF.
REQ-034 Three UNLOCKs with 32'h0 -> three rejects, locked_out=1, req_ready=0 for 1024 cycles, then LOCKED; correct UNLOCK then ok.
REQ-035 WRITE 32'h1234_5678 while LOCKED -> resp_ok=0, no key_wr_en, fail count unchanged (two bad UNLOCKs afterward do not trigger lockout).
REQ-036 UNLOCK ok, 256 idle cycles, WRITE -> rejected; READ with KEY_READBACK_EN after fresh UNLOCK -> ok + key_rd_en, without macro -> reject.
REQ-037 UNLOCK ok, SEAL -> sealed=1; subsequent correct UNLOCK/WRITE rejected; rst -> sealed=0, LOCKED.
REQ-038 Assert rst the cycle after a WRITE is accepted -> no resp_valid, no key_wr_en, all outputs at reset values next cycle.
